// File: rtl/gem_cluster_pkg.sv
// Shared cluster-word definitions for the GEM trigger path: field widths,
// the strip count that bounds a legal address, and the validity test.
package gem_cluster_pkg;

    localparam int CLUSTER_W = 14;
    localparam int ADR_W     = 11;
    localparam int CNT_W     = 3;
    localparam int NSTRIPS   = 1536;
    localparam int BX_MAX    = 3563;

    // Cluster word as produced by cluster_packer: cnt[13:11], adr[10:0].
    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic [ADR_W-1:0] adr;
    } cluster_t;

    // A cluster is real only when its address lands on a strip; everything
    // above (including the all-ones idle word) is filler from the packer.
    function automatic logic cluster_is_valid(input cluster_t word);
        return word.adr < ADR_W'(NSTRIPS);
    endfunction

endpackage

// File: rtl/cluster_mwfifo.sv
// Multi-write FIFO: up to NLANES masked entries are compacted into
// consecutive slots per cycle, one show-ahead read per cycle.
module cluster_mwfifo #(
    parameter int NLANES = 8,
    parameter int W      = 26,
    parameter int DEPTH  = 32
) (
    input  logic                        clock4x,
    input  logic                        global_reset_n,
    input  logic                        wr_en,
    input  logic [NLANES-1:0]           wr_mask,
    input  logic [NLANES*W-1:0]         wr_data,
    input  logic                        rd_ready,
    output logic                        rd_valid,
    output logic [W-1:0]                rd_data,
    output logic [$clog2(DEPTH):0]      occupancy,
    output logic [$clog2(NLANES+1)-1:0] wr_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam int CW = $clog2(NLANES + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] free_slots;
    logic [OW-1:0] prefix;
    logic [NLANES-1:0] lane_we;
    logic [AW-1:0] lane_addr [NLANES];
    logic [CW-1:0] n_accepted;
    logic          pop;

    // Compacting write: each masked lane lands at wr_ptr plus the number of
    // masked lanes below it; lanes beyond the free space are refused.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        free_slots = OW'(DEPTH) - occupancy;
        prefix     = '0;
        n_accepted = '0;
        lane_we    = '0;
        for (int i = 0; i < NLANES; i++) begin
            lane_addr[i] = wr_ptr + prefix[AW-1:0];
            lane_we[i]   = wr_en && wr_mask[i] && (prefix < free_slots);
            n_accepted   = n_accepted + CW'(lane_we[i]);
            prefix       = prefix + OW'(wr_mask[i]);
        end
    end

    assign wr_count = n_accepted;
    assign rd_valid = (occupancy != '0);
    assign pop      = rd_valid && rd_ready;
    // Idle output is forced to zero so stale storage never reaches the link.
    assign rd_data  = rd_valid ? mem[rd_ptr] : '0;

    // Entry storage, written by every accepting lane in the same cycle.
    // NOTE: the array has no reset; occupancy gates rd_data, so flushing the
    // pointers is enough and the storage maps onto plain RAM/registers.
    always_ff @(posedge clock4x) begin
        for (int i = 0; i < NLANES; i++) begin
            if (lane_we[i]) begin
                mem[lane_addr[i]] <= wr_data[i*W +: W];
            end
        end
    end

    // Pointer and occupancy bookkeeping; a same-cycle push and pop both count.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!global_reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            wr_ptr    <= wr_ptr + AW'(n_accepted);
            rd_ptr    <= rd_ptr + AW'(pop);
            occupancy <= occupancy + OW'(n_accepted) - OW'(pop);
        end
    end

endmodule

// File: rtl/cluster_link_scheduler.sv
// Per-BX cluster intake to the trigger link: filters idle/invalid words,
// tags survivors with the BX number, buffers them and throttles the packer.
module cluster_link_scheduler #(
    parameter int NCLUSTERS = 8,
    parameter int CLUSTER_W = gem_cluster_pkg::CLUSTER_W,
    parameter int DEPTH     = 32,
    parameter int TRUNC_HI  = 24,
    parameter int TRUNC_LO  = 8,
    parameter int BXW       = 12,
    parameter int BX_MAX    = gem_cluster_pkg::BX_MAX
) (
    input  logic                           clock4x,
    input  logic                           global_reset_n,
    input  logic                           bx0,
    input  logic [NCLUSTERS*CLUSTER_W-1:0] clusters_in,
    input  logic                           clusters_valid,
    input  logic                           link_ready,
    output logic                           link_valid,
    output logic [BXW+CLUSTER_W-1:0]       link_data,
    output logic                           truncate_clusters,
    output logic [15:0]                    overflow_cnt,
    output logic [$clog2(DEPTH):0]         fifo_occupancy
);

    import gem_cluster_pkg::*;

    localparam int EW = BXW + CLUSTER_W;
    localparam int OW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(NCLUSTERS + 1);

    logic [1:0]              phase;
    logic [BXW-1:0]          bx;
    logic [NCLUSTERS-1:0]    valid_mask;
    logic [NCLUSTERS*EW-1:0] lane_data;
    logic [CW-1:0]           n_valid;
    logic [CW-1:0]           n_written;
    logic [CW-1:0]           n_dropped;
    logic [16:0]             ovf_sum;

    // Classify each lane and pair it with the current BX tag.
    always_comb begin
        valid_mask = '0;
        lane_data  = '0;
        n_valid    = '0;
        for (int i = 0; i < NCLUSTERS; i++) begin
            valid_mask[i]          = cluster_is_valid(clusters_in[i*CLUSTER_W +: CLUSTER_W]);
            lane_data[i*EW +: EW]  = {bx, clusters_in[i*CLUSTER_W +: CLUSTER_W]};
            n_valid                = n_valid + CW'(valid_mask[i]);
        end
    end

    // Valid clusters the FIFO could not take are the drops for this strobe.
    always_comb begin
        n_dropped = clusters_valid ? (n_valid - n_written) : '0;
        ovf_sum   = {1'b0, overflow_cnt} + 17'(n_dropped);
    end

    cluster_mwfifo #(
        .NLANES (NCLUSTERS),
        .W      (EW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock4x        (clock4x),
        .global_reset_n (global_reset_n),
        .wr_en          (clusters_valid),
        .wr_mask        (valid_mask),
        .wr_data        (lane_data),
        .rd_ready       (link_ready),
        .rd_valid       (link_valid),
        .rd_data        (link_data),
        .occupancy      (fifo_occupancy),
        .wr_count       (n_written)
    );

    // BX counter: four clock4x phases per BX, orbit sync overrides counting.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            phase <= '0;
            bx    <= '0;
        end else if (bx0) begin
            phase <= '0;
            bx    <= '0;
        end else begin
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
                bx <= (bx == BXW'(BX_MAX)) ? '0 : bx + BXW'(1);
            end
        end
    end

    // Saturating count of clusters lost to a full FIFO.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            overflow_cnt <= '0;
        end else if (ovf_sum[16]) begin
            overflow_cnt <= 16'hFFFF;
        end else begin
            overflow_cnt <= ovf_sum[15:0];
        end
    end

    // Truncation hysteresis on the registered occupancy: high mark sets,
    // low mark clears, the band in between holds the previous decision.
    always_ff @(posedge clock4x or negedge global_reset_n) begin
        if (!global_reset_n) begin
            truncate_clusters <= 1'b0;
        end else if (fifo_occupancy >= OW'(TRUNC_HI)) begin
            truncate_clusters <= 1'b1;
        end else if (fifo_occupancy <= OW'(TRUNC_LO)) begin
            truncate_clusters <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cluster_link_scheduler.sv
// Self-checking bench for cluster_link_scheduler: a validity table, directed
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_cluster_link_scheduler;

    localparam int NCL   = 8;
    localparam int CWD   = 14;
    localparam int DEPTH = 32;
    localparam int THI   = 24;
    localparam int TLO   = 8;
    localparam int BXW   = 12;
    localparam int BXMAX = 3563;
    localparam int EW    = BXW + CWD;
    localparam int OW    = 6;

    logic                 clock4x = 1'b0;
    logic                 global_reset_n = 1'b0;
    logic                 bx0 = 1'b0;
    logic [NCL*CWD-1:0]   clusters_in = '0;
    logic                 clusters_valid = 1'b0;
    logic                 link_ready = 1'b0;
    logic                 link_valid;
    logic [EW-1:0]        link_data;
    logic                 truncate_clusters;
    logic [15:0]          overflow_cnt;
    logic [OW-1:0]        fifo_occupancy;

    cluster_link_scheduler #(
        .NCLUSTERS (NCL), .CLUSTER_W (CWD), .DEPTH (DEPTH), .TRUNC_HI (THI),
        .TRUNC_LO (TLO), .BXW (BXW), .BX_MAX (BXMAX)
    ) dut (
        .clock4x           (clock4x),
        .global_reset_n    (global_reset_n),
        .bx0               (bx0),
        .clusters_in       (clusters_in),
        .clusters_valid    (clusters_valid),
        .link_ready        (link_ready),
        .link_valid        (link_valid),
        .link_data         (link_data),
        .truncate_clusters (truncate_clusters),
        .overflow_cnt      (overflow_cnt),
        .fifo_occupancy    (fifo_occupancy)
    );

    always #5 clock4x = ~clock4x;

    int n_pass   = 0;
    int n_checks = 0;

    // Reference model: a plain queue of {bx, cluster} entries plus counters.
    logic [EW-1:0] mq[$];
    int  m_bx    = 0;
    int  m_phase = 0;
    int  m_ovf   = 0;
    bit  m_trunc = 1'b0;

    typedef struct {
        logic [CWD-1:0] word;
        logic           exp_valid;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        mq.delete();
        m_bx = 0; m_phase = 0; m_ovf = 0; m_trunc = 1'b0;
    endfunction

    // One clock4x of the specification's rules, from the inputs now applied.
    function automatic void model_step();
        int sz = mq.size();
        int room = DEPTH - sz;
        int dropped = 0;
        logic [EW-1:0] incoming[$];
        logic [CWD-1:0] w;
        if (clusters_valid) begin
            for (int i = 0; i < NCL; i++) begin
                w = clusters_in[i*CWD +: CWD];
                if (int'(w[10:0]) < 1536) begin
                    if (room > 0) begin
                        incoming.push_back({12'(m_bx), w});
                        room--;
                    end else begin
                        dropped++;
                    end
                end
            end
        end
        if (sz > 0 && link_ready) void'(mq.pop_front());
        foreach (incoming[k]) mq.push_back(incoming[k]);
        m_ovf = (m_ovf + dropped > 65535) ? 65535 : m_ovf + dropped;
        if (sz >= THI) m_trunc = 1'b1;
        else if (sz <= TLO) m_trunc = 1'b0;
        if (bx0) begin
            m_bx = 0; m_phase = 0;
        end else begin
            if (m_phase == 3) m_bx = (m_bx == BXMAX) ? 0 : m_bx + 1;
            m_phase = (m_phase + 1) % 4;
        end
    endfunction

    task automatic step();
        if (global_reset_n) model_step();
        @(posedge clock4x);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [EW-1:0] head;
        head = (mq.size() != 0) ? mq[0] : '0;
        check({tag, "_valid"}, 32'(link_valid), 32'(mq.size() != 0));
        check({tag, "_data"},  32'(link_data), 32'(head));
        check({tag, "_occ"},   32'(fifo_occupancy), 32'(mq.size()));
        check({tag, "_trunc"}, 32'(truncate_clusters), 32'(m_trunc));
        check({tag, "_ovf"},   32'(overflow_cnt), 32'(m_ovf));
    endtask

    task automatic set_idle();
        for (int i = 0; i < NCL; i++) clusters_in[i*CWD +: CWD] = 14'h07FF;
    endtask

    task automatic set_lane(input int i, input logic [2:0] cnt, input logic [10:0] adr);
        clusters_in[i*CWD +: CWD] = {cnt, adr};
    endtask

    task automatic fill_all_valid();
        for (int i = 0; i < NCL; i++) set_lane(i, 3'($urandom_range(0, 7)), 11'($urandom_range(0, 1535)));
    endtask

    task automatic fill_random();
        for (int i = 0; i < NCL; i++) begin
            if ($urandom_range(0, 1) == 1) set_lane(i, 3'($urandom_range(0, 7)), 11'($urandom_range(0, 1535)));
            else set_lane(i, 3'($urandom_range(0, 7)), 11'($urandom_range(1536, 2047)));
        end
    endtask

    task automatic do_reset();
        global_reset_n = 1'b0;
        bx0 = 1'b0; clusters_valid = 1'b0; link_ready = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clock4x);
        #1;
        global_reset_n = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_occ[5];
        int tag_exp;
        int pct;
        int pcts[3];

        exp_occ = '{8, 16, 24, 32, 32};
        pcts    = '{15, 60, 95};
        vecs[0] = '{14'h0000, 1'b1};   // adr 0
        vecs[1] = '{14'h05FF, 1'b1};   // adr 1535, last strip
        vecs[2] = '{14'h0600, 1'b0};   // adr 1536, first invalid
        vecs[3] = '{14'h07FF, 1'b0};   // idle word
        vecs[4] = '{14'h3DFF, 1'b1};   // cnt 7, adr 1535
        vecs[5] = '{14'h3E00, 1'b0};   // cnt 7, adr 1536
        vecs[6] = '{14'h1234, 1'b1};   // cnt 2, adr 0x234
        vecs[7] = '{14'h2700, 1'b0};   // cnt 4, adr 0x700

        // Reset held with live traffic: every output stays at zero.
        global_reset_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            fill_all_valid();
            clusters_valid = 1'b1;
            link_ready = 1'($urandom_range(0, 1));
            @(posedge clock4x);
            #1;
            check("rst_valid", 32'(link_valid), 32'd0);
            check("rst_data", 32'(link_data), 32'd0);
            check("rst_occ", 32'(fifo_occupancy), 32'd0);
            check("rst_trunc", 32'(truncate_clusters), 32'd0);
            check("rst_ovf", 32'(overflow_cnt), 32'd0);
        end
        model_reset();
        clusters_valid = 1'b0;
        set_idle();
        global_reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_valid", 32'(link_valid), 32'd0);
        end

        // Validity table: one candidate in lane 0, idle elsewhere.
        link_ready = 1'b1;
        foreach (vecs[v]) begin
            set_idle();
            clusters_in[CWD-1:0] = vecs[v].word;
            clusters_valid = 1'b1;
            step();
            clusters_valid = 1'b0;
            set_idle();
            check("tbl_valid", 32'(link_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) check("tbl_data", 32'(link_data[CWD-1:0]), 32'(vecs[v].word));
            step();
            check("tbl_drain", 32'(fifo_occupancy), 32'd0);
        end
        check("tbl_no_drops", 32'(overflow_cnt), 32'd0);

        // Single cluster tagged with bx 7.
        do_reset();
        link_ready = 1'b1;
        repeat (9) step();
        bx0 = 1'b1;
        step();
        bx0 = 1'b0;
        repeat (28) step();
        set_lane(0, 3'd2, 11'd5);
        clusters_valid = 1'b1;
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("single_valid", 32'(link_valid), 32'd1);
        check("single_data", 32'(link_data), 32'({12'd7, 14'h1005}));
        step();
        check("single_gone", 32'(link_valid), 32'd0);
        check("single_ovf", 32'(overflow_cnt), 32'd0);

        // Compaction: valid lanes 1, 4, 6 leave in ascending lane order.
        set_lane(1, 3'd0, 11'd100);
        set_lane(4, 3'd0, 11'd400);
        set_lane(6, 3'd0, 11'd600);
        clusters_valid = 1'b1;
        tag_exp = m_bx;
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("cmp0_adr", 32'(link_data[10:0]), 32'd100);
        check("cmp0_tag", 32'(link_data[EW-1:CWD]), 32'(tag_exp));
        step();
        check("cmp1_adr", 32'(link_data[10:0]), 32'd400);
        check("cmp1_tag", 32'(link_data[EW-1:CWD]), 32'(tag_exp));
        step();
        check("cmp2_adr", 32'(link_data[10:0]), 32'd600);
        check("cmp2_tag", 32'(link_data[EW-1:CWD]), 32'(tag_exp));
        step();
        check("cmp_empty", 32'(link_valid), 32'd0);

        // Backpressure to full, overflow, then drain through the low mark.
        do_reset();
        for (int s = 0; s < 5; s++) begin
            fill_all_valid();
            clusters_valid = 1'b1;
            step();
            check("bp_occ", 32'(fifo_occupancy), 32'(exp_occ[s]));
            check("bp_trunc", 32'(truncate_clusters), 32'(s >= 3));
            check("bp_ovf", 32'(overflow_cnt), (s == 4) ? 32'd8 : 32'd0);
            check_model("bp");
        end
        clusters_valid = 1'b0;
        set_idle();
        link_ready = 1'b1;
        for (int k = 0; k < 40 && fifo_occupancy != 8; k++) begin
            step();
            check_model("drain");
        end
        check("drain_at8_occ", 32'(fifo_occupancy), 32'd8);
        check("drain_at8_trunc", 32'(truncate_clusters), 32'd1);
        step();
        check("drain_at7_occ", 32'(fifo_occupancy), 32'd7);
        check("drain_at7_trunc", 32'(truncate_clusters), 32'd0);

        // Full FIFO with a same-cycle pop: nothing pushed, all three dropped.
        do_reset();
        for (int s = 0; s < 4; s++) begin
            fill_all_valid();
            clusters_valid = 1'b1;
            step();
        end
        check("full_occ", 32'(fifo_occupancy), 32'd32);
        set_idle();
        set_lane(0, 3'd1, 11'd11);
        set_lane(3, 3'd1, 11'd33);
        set_lane(7, 3'd1, 11'd77);
        link_ready = 1'b1;
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("fullpop_occ", 32'(fifo_occupancy), 32'd31);
        check("fullpop_ovf", 32'(overflow_cnt), 32'd3);
        check_model("fullpop");

        // bx0 realignment, then free-run through the 3563 -> 0 wrap.
        do_reset();
        link_ready = 1'b1;
        repeat (37) step();
        bx0 = 1'b1;
        step();
        bx0 = 1'b0;
        set_lane(0, 3'd1, 11'd10);
        clusters_valid = 1'b1;
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("bx0_tag", 32'(link_data[EW-1:CWD]), 32'd0);
        repeat (14251) step();
        set_lane(0, 3'd1, 11'd20);
        clusters_valid = 1'b1;
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("bxmax_tag", 32'(link_data[EW-1:CWD]), 32'd3563);
        repeat (3) step();
        set_lane(0, 3'd1, 11'd30);
        clusters_valid = 1'b1;
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("bxwrap_tag", 32'(link_data[EW-1:CWD]), 32'd0);
        check_model("bx");

        // Reset asserted mid-cycle with ten entries buffered.
        do_reset();
        fill_all_valid();
        clusters_valid = 1'b1;
        step();
        set_idle();
        set_lane(0, 3'd0, 11'd1);
        set_lane(1, 3'd0, 11'd2);
        step();
        clusters_valid = 1'b0;
        set_idle();
        check("pre_rst_occ", 32'(fifo_occupancy), 32'd10);
        check("pre_rst_valid", 32'(link_valid), 32'd1);
        #2;
        global_reset_n = 1'b0;
        #1;
        check("async_rst_occ", 32'(fifo_occupancy), 32'd0);
        check("async_rst_valid", 32'(link_valid), 32'd0);
        check("async_rst_data", 32'(link_data), 32'd0);
        model_reset();
        @(posedge clock4x);
        #1;
        global_reset_n = 1'b1;

        // Randomized traffic with varying link throughput.
        pct = pcts[0];
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) pct = pcts[(c / 250) % 3];
            fill_random();
            clusters_valid = 1'($urandom_range(0, 1));
            link_ready = 1'($urandom_range(0, 99) < pct);
            bx0 = 1'($urandom_range(0, 299) == 0);
            step();
            check_model("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
